// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, redirect flushes and memory-busy freezes.
// Also keeps a sticky memory-timeout flag and a saturating count of stall cycles.
module hazard_ctrl #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs_ID,
  input  logic [4:0]  Rt_ID,
  input  logic        UseRs_ID,
  input  logic        UseRt_ID,
  input  logic        MemRead_IDEX,
  input  logic [4:0]  WriteReg_IDEX,
  input  logic        Redirect_EX,
  input  logic        MemBusy,
  output logic        PC_Stall,
  output logic        IFID_Stall,
  output logic        IFID_Flush,
  output logic        ID_Stall,
  output logic        ID_Flush,
  output logic        EXMEM_Stall,
  output logic        MemTimeout,
  output logic [15:0] StallCount
);

  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MEM_WAIT  = 2'd1,
    REDIRECT2 = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             pending_q, pending_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [15:0]      stall_count_q, stall_count_d;

  logic load_use;

  assign load_use = MemRead_IDEX & (WriteReg_IDEX != 5'd0) &
                    ((UseRs_ID & (Rs_ID == WriteReg_IDEX)) |
                     (UseRt_ID & (Rt_ID == WriteReg_IDEX)));

  // NOTE: the reset is synchronous, so it is folded into the _d logic and the
  // flops below are plain registers updated with non-blocking assignments.
  always_ff @(posedge clk) begin
    state_q       <= state_d;
    wait_cnt_q    <= wait_cnt_d;
    pending_q     <= pending_d;
    mem_timeout_q <= mem_timeout_d;
    stall_count_q <= stall_count_d;
  end

  // NOTE: every variable gets a default first so no latch is inferred.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    pending_d     = pending_q;
    mem_timeout_d = mem_timeout_q | (wait_cnt_q == MAX_CNT);
    stall_count_d = (PC_Stall && stall_count_q != 16'hFFFF) ? stall_count_q + 16'd1
                                                              : stall_count_q;
    if (rst) begin
      state_d       = RUN;
      wait_cnt_d    = '0;
      pending_d     = 1'b0;
      mem_timeout_d = 1'b0;
      stall_count_d = 16'd0;
    end else if (MemBusy) begin
      // A busy cycle in REDIRECT2 interrupts the flush sequence, so it is owed later.
      state_d    = MEM_WAIT;
      wait_cnt_d = (wait_cnt_q == MAX_CNT) ? wait_cnt_q : wait_cnt_q + 1'b1;
      pending_d  = pending_q | Redirect_EX | (state_q == REDIRECT2);
    end else begin
      wait_cnt_d = '0;
      pending_d  = 1'b0;
      case (state_q)
        REDIRECT2: state_d = RUN;
        default:   state_d = (Redirect_EX || pending_q) ? REDIRECT2 : RUN;
      endcase
    end
  end

  always_comb begin
    PC_Stall    = 1'b0;
    IFID_Stall  = 1'b0;
    IFID_Flush  = 1'b0;
    ID_Stall    = 1'b0;
    ID_Flush    = 1'b0;
    EXMEM_Stall = 1'b0;
    if (!rst) begin
      if (MemBusy) begin
        PC_Stall    = 1'b1;
        IFID_Stall  = 1'b1;
        ID_Stall    = 1'b1;
        EXMEM_Stall = 1'b1;
      end else if (state_q == REDIRECT2) begin
        IFID_Flush = 1'b1;
      end else if (Redirect_EX || pending_q) begin
        IFID_Flush = 1'b1;
        ID_Flush   = 1'b1;
      end else if (load_use) begin
        PC_Stall   = 1'b1;
        IFID_Stall = 1'b1;
        ID_Flush   = 1'b1;
      end
    end
  end

  assign MemTimeout = mem_timeout_q;
  assign StallCount = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: single-cycle vector table, directed multi-cycle sequences,
// and randomized traffic checked against a behavioural model.
module tb_hazard_ctrl;

  localparam int MAX_WAIT = 15;

  // Output vectors: {PC_Stall, IFID_Stall, IFID_Flush, ID_Stall, ID_Flush, EXMEM_Stall}
  localparam logic [5:0] O_NONE   = 6'b000000;
  localparam logic [5:0] O_FREEZE = 6'b110101;
  localparam logic [5:0] O_FLUSH  = 6'b001010;
  localparam logic [5:0] O_FLUSH2 = 6'b001000;
  localparam logic [5:0] O_BUBBLE = 6'b110010;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs, rt, wr;
  logic        urs, urt, mr, redir, busy;
  logic        pc_stall, ifid_stall, ifid_flush, id_stall, id_flush, exmem_stall;
  logic        mem_timeout;
  logic [15:0] stall_count;

  int total = 0;
  int bad   = 0;

  hazard_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .Rs_ID(rs), .Rt_ID(rt), .UseRs_ID(urs), .UseRt_ID(urt),
    .MemRead_IDEX(mr), .WriteReg_IDEX(wr), .Redirect_EX(redir), .MemBusy(busy),
    .PC_Stall(pc_stall), .IFID_Stall(ifid_stall), .IFID_Flush(ifid_flush),
    .ID_Stall(id_stall), .ID_Flush(id_flush), .EXMEM_Stall(exmem_stall),
    .MemTimeout(mem_timeout), .StallCount(stall_count)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] outs();
    return {pc_stall, ifid_stall, ifid_flush, id_stall, id_flush, exmem_stall};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic r, input logic b, input logic rd, input logic m,
                        input logic [4:0] w, input logic [4:0] s, input logic us,
                        input logic [4:0] t, input logic ut);
    rst = r; busy = b; redir = rd; mr = m; wr = w; rs = s; urs = us; rt = t; urt = ut;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset with noisy inputs: outputs must stay quiet while rst is high.
  task automatic do_reset();
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 5'd3, 1'b1, 5'd3, 1'b1);
    #3 check("outs_in_reset", 32'(outs()), 32'(O_NONE));
    tick();
    idle();
  endtask

  typedef struct {
    logic       b, rd, m;
    logic [4:0] w, s, t;
    logic       us, ut;
    logic [5:0] exp;
  } vec_t;

  // Behavioural model: pending redirect, second-flush owed, busy run length.
  bit m_pending, m_second, m_timeout;
  int m_run, m_stalls;

  function automatic logic [5:0] model_out();
    logic lu;
    lu = mr && wr != 0 && ((urs && rs == wr) || (urt && rt == wr));
    if (rst)                     return O_NONE;
    if (busy)                    return O_FREEZE;
    if (m_second)                return O_FLUSH2;
    if (redir || m_pending)      return O_FLUSH;
    if (lu)                      return O_BUBBLE;
    return O_NONE;
  endfunction

  task automatic model_edge(input logic [5:0] o);
    if (rst) begin
      m_pending = 0; m_second = 0; m_timeout = 0; m_run = 0; m_stalls = 0;
    end else begin
      if (m_run == MAX_WAIT) m_timeout = 1;
      if (o[5] && m_stalls < 65535) m_stalls++;
      if (busy) begin
        m_pending = m_pending | redir | m_second;
        m_second  = 0;
        if (m_run < MAX_WAIT) m_run++;
      end else begin
        m_run = 0;
        if (m_second) m_second = 0;
        else if (redir || m_pending) begin
          m_second  = 1;
          m_pending = 0;
        end
      end
    end
  endtask

  initial begin
    vec_t vecs[10];
    logic [5:0] e;

    idle();
    rst = 1'b1;
    tick();
    tick();
    idle();
    #3;
    check("reset_outs", 32'(outs()), 32'(O_NONE));
    check("reset_timeout", 32'(mem_timeout), 0);
    check("reset_stallcount", 32'(stall_count), 0);

    // Single-cycle behaviour from RUN.
    vecs[0] = '{1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, O_NONE};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, O_BUBBLE};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 5'd9, 5'd1, 5'd9, 1'b1, 1'b1, O_BUBBLE};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, O_NONE};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, O_NONE};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, O_NONE};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, O_FLUSH};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, O_FREEZE};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, O_FLUSH};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 5'd7, 5'd6, 5'd8, 1'b1, 1'b1, O_NONE};
    for (int i = 0; i < 10; i++) begin
      do_reset();
      set_in(1'b0, vecs[i].b, vecs[i].rd, vecs[i].m, vecs[i].w, vecs[i].s, vecs[i].us,
             vecs[i].t, vecs[i].ut);
      #3 check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
      tick();
    end

    // Load-use: one bubble, StallCount 0 -> 1.
    do_reset();
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    #3 check("lu_outs", 32'(outs()), 32'(O_BUBBLE));
    check("lu_count_before", 32'(stall_count), 0);
    tick();
    idle();
    #3 check("lu_after", 32'(outs()), 32'(O_NONE));
    check("lu_count_after", 32'(stall_count), 1);

    // Redirect: full flush, then IFID_Flush only, then quiet.
    do_reset();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    #3 check("redir_c1", 32'(outs()), 32'(O_FLUSH));
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    #3 check("redir_c2_lu_ignored", 32'(outs()), 32'(O_FLUSH2));
    tick();
    idle();
    #3 check("redir_c3", 32'(outs()), 32'(O_NONE));
    tick();

    // Busy for 3 cycles with a redirect in cycle 2.
    do_reset();
    for (int c = 1; c <= 3; c++) begin
      set_in(1'b0, 1'b1, c == 2, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
      #3 check($sformatf("busy_redir_freeze%0d", c), 32'(outs()), 32'(O_FREEZE));
      tick();
    end
    idle();
    #3 check("busy_redir_flush", 32'(outs()), 32'(O_FLUSH));
    tick();
    #3 check("busy_redir_flush2", 32'(outs()), 32'(O_FLUSH2));
    tick();
    #3 check("busy_redir_quiet", 32'(outs()), 32'(O_NONE));
    check("busy_redir_count", 32'(stall_count), 3);

    // Timeout: 20 busy cycles, flag from the 16th edge on, sticky until rst.
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      set_in(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
      tick();
      check($sformatf("timeout_c%0d", c), 32'(mem_timeout), 32'(c >= 16));
    end
    idle();
    for (int c = 0; c < 4; c++) tick();
    check("timeout_sticky", 32'(mem_timeout), 1);
    check("timeout_count", 32'(stall_count), 20);
    rst = 1'b1;
    tick();
    idle();
    #3 check("timeout_cleared", 32'(mem_timeout), 0);

    // Reset in cycle 4 of a busy burst.
    do_reset();
    for (int c = 1; c <= 3; c++) begin
      set_in(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
      tick();
    end
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    #3 check("midwait_rst_outs", 32'(outs()), 32'(O_NONE));
    tick();
    idle();
    #3 check("midwait_outs", 32'(outs()), 32'(O_NONE));
    check("midwait_count", 32'(stall_count), 0);
    check("midwait_timeout", 32'(mem_timeout), 0);
    tick();
    #3 check("midwait_no_pending", 32'(outs()), 32'(O_NONE));

    // Randomized traffic against the model.
    do_reset();
    m_pending = 0; m_second = 0; m_timeout = 0; m_run = 0; m_stalls = 0;
    for (int n = 0; n < 3000; n++) begin
      set_in($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 30,
             $urandom_range(0, 99) < 15, 1'($urandom),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
             5'($urandom_range(0, 3)), 1'($urandom));
      #3;
      e = model_out();
      check("rand_outs", 32'(outs()), 32'(e));
      check("rand_timeout", 32'(mem_timeout), 32'(m_timeout));
      check("rand_count", 32'(stall_count), 32'(m_stalls));
      model_edge(e);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
